// File: rtl/inst_fetch_cache.sv
// Instruction fetch through a direct-mapped one-word-per-line I-cache, filled byte by byte from memory.
// Hit latency 1 cycle; a miss holds the PC stage through stall_req_o until the line fill completes.
module inst_fetch_cache #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 7,
    parameter int TAG_W      = ADDR_W - INDEX_BITS - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              stall_req_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_busy_i,
    input  logic              mem_done_i,
    input  logic [7:0]        mem_data_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o,
    output logic              if_valid_o
);
    localparam int LINES = 1 << INDEX_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]            state;
    logic [1:0]            k;
    logic [ADDR_W-1:0]     base;
    logic [31:0]           fill_buf;
    logic                  fill_full;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fidx;
    logic [TAG_W-1:0]      tag;
    logic [TAG_W-1:0]      ftag;
    logic                  hit;
    logic                  last_byte;
    logic                  fill_done;
    logic [31:0]           fill_word;

    assign idx  = pc_i[INDEX_BITS+1:2];
    assign tag  = pc_i[ADDR_W-1:INDEX_BITS+2];
    assign fidx = base[INDEX_BITS+1:2];
    assign ftag = base[ADDR_W-1:INDEX_BITS+2];
    assign hit  = valid[idx] && (tag_mem[idx] == tag);

    // The last byte may have arrived during an IF/ID stall; fill_full remembers it until completion.
    assign last_byte = (state == S_WAIT) && (k == 2'd3) && (fill_full || mem_done_i);
    assign fill_done = last_byte && !stall_i && !flush_i && rdy && !rst;
    assign fill_word = {(fill_full ? fill_buf[31:24] : mem_data_i), fill_buf[23:0]};

    assign stall_req_o = !rst && ((state != S_IDLE) || !hit);
    assign mem_rd_o    = (state == S_REQ);
    assign mem_addr_o  = mem_rd_o ? (base + {{(ADDR_W-2){1'b0}}, k}) : '0;

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_mem[fidx] <= fill_word;
            tag_mem[fidx]  <= ftag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            base       <= '0;
            fill_buf   <= '0;
            fill_full  <= 1'b0;
            valid      <= '0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
            if_valid_o <= 1'b0;
        end else if (rdy) begin
            if (flush_i) begin
                state      <= S_IDLE;
                k          <= 2'd0;
                fill_full  <= 1'b0;
                if_valid_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!stall_i) begin
                            if (hit) begin
                                if_inst_o  <= data_mem[idx];
                                if_pc_o    <= pc_i;
                                if_valid_o <= 1'b1;
                            end else begin
                                if_valid_o <= 1'b0;
                                state      <= S_REQ;
                                k          <= 2'd0;
                                fill_full  <= 1'b0;
                                base       <= {pc_i[ADDR_W-1:2], 2'b00};
                            end
                        end
                    end
                    S_REQ: begin
                        if (!mem_busy_i) state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (last_byte) begin
                            if (stall_i) begin
                                if (mem_done_i) begin
                                    fill_buf[31:24] <= mem_data_i;
                                    fill_full       <= 1'b1;
                                end
                            end else begin
                                valid[fidx] <= 1'b1;
                                if_inst_o   <= fill_word;
                                if_pc_o     <= base;
                                if_valid_o  <= 1'b1;
                                fill_full   <= 1'b0;
                                state       <= S_IDLE;
                            end
                        end else if (mem_done_i) begin
                            fill_buf[{k, 3'b000} +: 8] <= mem_data_i;
                            k                          <= k + 2'd1;
                            state                      <= S_REQ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed bench for inst_fetch_cache: a vector table of fetches plus hand sequences for busy, rdy, reset and flush.
module tb_inst_fetch_cache;
    logic        clk = 1'b0;
    logic        rst, rdy, flush_i, stall_i;
    logic [31:0] pc_i;
    logic        stall_req_o, mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_busy_i;
    logic        mem_done_i = 1'b0;
    logic [7:0]  mem_data_i = 8'h00;
    logic [31:0] if_pc_o, if_inst_o;
    logic        if_valid_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    inst_fetch_cache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .flush_i(flush_i), .stall_i(stall_i),
        .stall_req_o(stall_req_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_busy_i(mem_busy_i), .mem_done_i(mem_done_i), .mem_data_i(mem_data_i),
        .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'h00;
            32'h3: return 8'h00;
            default: return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory controller responder: accepts a non-busy request and returns the byte one cycle later.
    always @(posedge clk) begin
        mem_done_i <= 1'b0;
        if (!rst && rdy && !flush_i && mem_rd_o && !mem_busy_i) begin
            mem_done_i <= 1'b1;
            mem_data_i <= mem_byte(mem_addr_o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents pc and runs edges until if_valid_o (bounded). Called at posedge+1.
    task automatic run_fetch(input logic [31:0] pc, output int cyc, output int st_hi,
                             output logic [31:0] first_a, output logic st0);
        pc_i = pc;
        #1;
        st0     = stall_req_o;
        cyc     = 0;
        st_hi   = 0;
        first_a = 32'hFFFF_FFFF;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (mem_rd_o && first_a === 32'hFFFF_FFFF) first_a = mem_addr_o;
            if (!if_valid_o && stall_req_o) st_hi++;
        end while (!if_valid_o && cyc < 60);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] inst;
    } vec_t;

    vec_t        tbl [11];
    int          cyc, st_hi, left;
    logic [31:0] first_a;
    logic        st0, found;

    initial begin
        tbl[0]  = '{32'h000, 1'b1, 32'h0000_0513};
        tbl[1]  = '{32'h004, 1'b0, exp_word(32'h004)};
        tbl[2]  = '{32'h008, 1'b0, exp_word(32'h008)};
        tbl[3]  = '{32'h004, 1'b1, exp_word(32'h004)};
        tbl[4]  = '{32'h008, 1'b1, exp_word(32'h008)};
        tbl[5]  = '{32'h000, 1'b1, 32'h0000_0513};
        tbl[6]  = '{32'h204, 1'b0, exp_word(32'h204)};
        tbl[7]  = '{32'h004, 1'b0, exp_word(32'h004)};
        tbl[8]  = '{32'h204, 1'b0, exp_word(32'h204)};
        tbl[9]  = '{32'h204, 1'b1, exp_word(32'h204)};
        tbl[10] = '{32'h008, 1'b1, exp_word(32'h008)};

        rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; stall_i = 1'b0; mem_busy_i = 1'b0; pc_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
        chk("rst_mem_rd", {31'b0, mem_rd_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        rst = 1'b0;

        // Cold miss: one IDLE decode edge, then eight fill cycles with stall high.
        run_fetch(32'h0, cyc, st_hi, first_a, st0);
        chk("cold_stall_now", {31'b0, st0}, 32'd1);
        chk("cold_stall_cycles", st_hi, 32'd8);
        chk("cold_latency", cyc, 32'd9);
        chk("cold_first_addr", first_a, 32'h0);
        chk("cold_inst", if_inst_o, 32'h0000_0513);
        chk("cold_pc", if_pc_o, 32'h0);
        chk("cold_valid", {31'b0, if_valid_o}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_fetch(tbl[i].pc, cyc, st_hi, first_a, st0);
            chk($sformatf("v%0d_stall", i), {31'b0, st0}, {31'b0, !tbl[i].hit});
            chk($sformatf("v%0d_latency", i), cyc, tbl[i].hit ? 32'd1 : 32'd9);
            chk($sformatf("v%0d_memreq", i), first_a, tbl[i].hit ? 32'hFFFF_FFFF : tbl[i].pc);
            chk($sformatf("v%0d_inst", i), if_inst_o, tbl[i].inst);
            chk($sformatf("v%0d_pc", i), if_pc_o, tbl[i].pc);
        end

        // stall_i holds the delivered instruction even when the new pc hits.
        stall_i = 1'b1;
        pc_i    = 32'h000;
        @(posedge clk); #1;
        chk("stall_hold_pc", if_pc_o, 32'h008);
        chk("stall_hold_valid", {31'b0, if_valid_o}, 32'd1);
        stall_i = 1'b0;
        @(posedge clk); #1;
        chk("stall_release_pc", if_pc_o, 32'h000);
        chk("stall_release_inst", if_inst_o, 32'h0000_0513);

        // Busy held for three cycles on byte 2 of the fill.
        pc_i  = 32'h100;
        cyc   = 0;
        left  = 0;
        found = 1'b0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (left > 0) begin
                chk("busy_addr_hold", mem_addr_o, 32'h102);
                left--;
                if (left == 0) mem_busy_i = 1'b0;
            end else if (!found && mem_rd_o && mem_addr_o == 32'h102) begin
                found      = 1'b1;
                mem_busy_i = 1'b1;
                left       = 3;
            end
        end while (!if_valid_o && cyc < 60);
        mem_busy_i = 1'b0;
        chk("busy_seen", {31'b0, found}, 32'd1);
        chk("busy_latency", cyc, 32'd12);
        chk("busy_inst", if_inst_o, exp_word(32'h100));

        // rdy low for five cycles while requesting byte 1 freezes everything.
        pc_i  = 32'h300;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = mem_rd_o && (mem_addr_o == 32'h301);
        end
        chk("rdy_reach_req1", {31'b0, found}, 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rdy_hold_stall", {31'b0, stall_req_o}, 32'd1);
            chk("rdy_hold_rd", {31'b0, mem_rd_o}, 32'd1);
            chk("rdy_hold_addr", mem_addr_o, 32'h301);
            chk("rdy_hold_valid", {31'b0, if_valid_o}, 32'd0);
        end
        rdy   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = mem_rd_o && (mem_addr_o == 32'h302);
        end
        chk("rdy_resume_req2", {31'b0, found}, 32'd1);

        // Reset mid-fill.
        rst  = 1'b1;
        pc_i = 32'h0;
        @(posedge clk); #1;
        chk("midrst_stall", {31'b0, stall_req_o}, 32'd0);
        chk("midrst_rd", {31'b0, mem_rd_o}, 32'd0);
        chk("midrst_addr", mem_addr_o, 32'd0);
        chk("midrst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("midrst_pc", if_pc_o, 32'd0);
        chk("midrst_inst", if_inst_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("postrst_miss", {31'b0, stall_req_o}, 32'd1);

        // Flush while waiting on byte 1: the partial line must not be written.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = mem_rd_o && (mem_addr_o == 32'h001);
        end
        chk("flush_reach_req1", {31'b0, found}, 32'd1);
        @(posedge clk); #1;
        chk("flush_in_wait", {31'b0, mem_rd_o}, 32'd0);
        flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_valid", {31'b0, if_valid_o}, 32'd0);
        chk("flush_rd", {31'b0, mem_rd_o}, 32'd0);
        flush_i = 1'b0;
        run_fetch(32'h040, cyc, st_hi, first_a, st0);
        chk("redirect_first_addr", first_a, 32'h040);
        chk("redirect_latency", cyc, 32'd9);
        chk("redirect_inst", if_inst_o, exp_word(32'h040));
        run_fetch(32'h000, cyc, st_hi, first_a, st0);
        chk("refetch0_miss", {31'b0, st0}, 32'd1);
        chk("refetch0_latency", cyc, 32'd9);
        chk("refetch0_inst", if_inst_o, 32'h0000_0513);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
